rca_config_loader: RTL and testbench
====================================

# rca_config_loader

Streaming configuration loader that drives the write side of the RCA configuration register file. It accepts a header word followed by N entry words over a valid/ready stream, and decodes each entry into one single-cycle write strobe: grid mux, IO mux, result mux, CPU src/dest reg address, or IO input map. It holds the target RCA select for the whole load and sits between the CPU-side config source (CSR/DMA) and the config register file.

## Interface
- NUM_RCAS, 4, number of accelerators
- NUM_READ_PORTS, 2, CPU source-register ports per RCA
- NUM_WRITE_PORTS, 2, CPU dest-register ports per RCA
- GRID_NUM_ROWS, 4, grid rows / IO units
- NUM_GRID_MUXES, 32, grid crossbar muxes
- GRID_MUX_INPUTS, 8; IO_UNIT_MUX_INPUTS, 8, mux input counts
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- cfg_data  in  32  stream word
- cfg_valid  in  1  word valid
- cfg_ready  out  1  loader accepts word
- cfg_abort  in  1  abandon current load
- busy  out  1  load in progress (LOAD state)
- done  out  1  one-cycle pulse at end of load
- err  out  1  sticky; error in current/last load, cleared by next header
- rca_sel  out  clog2(NUM_RCAS)  target RCA, held from header until next header
- cpu_fb_reg_addr_wr_en, cpu_nfb_reg_addr_wr_en  out  1 each
- cpu_src_dest_port  out  1  0 = src, 1 = dest
- cpu_port_sel  out  clog2(NUM_READ_PORTS); cpu_reg_addr  out  5
- grid_mux_wr_en  out  1; grid_mux_wr_addr  out  clog2(NUM_GRID_MUXES); new_grid_mux_sel  out  clog2(GRID_MUX_INPUTS)
- io_mux_wr_en  out  1; io_mux_addr  out  clog2(GRID_NUM_ROWS); new_io_mux_sel  out  clog2(IO_UNIT_MUX_INPUTS)
- rca_result_mux_wr_en  out  1; rca_result_mux_addr  out  clog2(NUM_WRITE_PORTS); new_rca_result_mux_sel  out  clog2(GRID_NUM_ROWS)
- rca_io_inp_map_wr_en  out  1; new_rca_io_inp_map  out  GRID_NUM_ROWS

## Operation
- Header word: [7:0] entry count N; [15:8] RCA id, low bits to rca_sel; the rest is reserved.
- Entry word: [31:29] type; [23:16] index; [15:0] value, truncated to the destination width.
- Types:
  - 0 grid mux
  - 1 IO mux
  - 2 result mux
  - 3 CPU src (fb_en, port=0)
  - 4 CPU dest fb (fb_en, port=1)
  - 5 CPU dest nfb (nfb_en, port=1)
  - 6 IO input map (value only)
  - 7 invalid: sets err, no strobe
- FSM states IDLE, LOAD, DONE.
  - IDLE: cfg_ready=1. Accepted word is the header: latch rca_sel, load remaining counter with N, clear err. N=0 goes to DONE; otherwise go to LOAD.
  - LOAD: cfg_ready=1. Each accepted entry decrements the counter. Accepting the entry when the counter is 1 moves to DONE.
  - DONE: cfg_ready=0, done=1 for one cycle, then IDLE.
- At most one write strobe per cycle. Only the strobe for the decoded type is asserted; all other enables are 0.
- cfg_abort in LOAD or DONE: next state IDLE. cfg_ready is 0 in the abort cycle, so the word is not accepted. No done pulse. Strobes already issued are not undone.

## Timing
- Every write strobe and its address/data are registered: asserted exactly the cycle after the entry handshake (cfg_valid & cfg_ready), for one cycle.
- The last entry's strobe coincides with the done pulse (the DONE cycle).
- Back-to-back entries give one strobe per cycle with no bubbles. A new header is accepted the cycle after DONE.
- cfg_ready is combinational from state and cfg_abort, and is 0 while rst_n is low.
- Reset values:
  - state IDLE
  - all enables 0, all address/data outputs 0
  - rca_sel 0, busy 0, done 0, err 0
- Reset mid-load clears everything asynchronously. A strobe pending for the next edge is suppressed.

## Configuration
- RCA_CFG_LOADER_RANGE_CHECK_EN defined: the following set err and produce no strobe:
  - index ≥ the destination entry count (NUM_GRID_MUXES, GRID_NUM_ROWS, NUM_WRITE_PORTS, or NUM_READ_PORTS for type 3)
  - value ≥ the destination mux input count
  - header RCA id ≥ NUM_RCAS: every entry of that load is consumed and suppressed.
- RCA_CFG_LOADER_RANGE_CHECK_EN undefined: index and value are truncated to the destination width and always written. Only type 7 sets err.

## Test plan
- Header N=3, rca=2, then entries {0,5,3},{1,1,7},{2,1,2} back-to-back: grid_mux_wr_en (addr 5, sel 3), then io_mux_wr_en (addr 1, sel 7), then rca_result_mux_wr_en (addr 1, sel 2) on consecutive cycles. rca_sel=2 throughout; done coincides with the third strobe.
- Header N=0 → done one cycle after the header handshake, no strobes, busy stays 0.
- Types 3/4/5 with index 1, value 17 → cpu_reg_addr=17, cpu_port_sel=1, with src_dest/fb/nfb as specified. Type 7 → err=1, no strobe; the next header clears err.
- cfg_valid toggled randomly and cfg_abort after 2 of 4 entries → exactly 2 strobes, no done, the next word is treated as a header.
- With RANGE_CHECK_EN, grid index 40 → no strobe, err=1. Without it → grid_mux_wr_addr=8.
- rst_n asserted in the cycle after an entry handshake → no strobe, all outputs 0, cfg_ready=0 until release.

Source files
------------

// File: rtl/rca_config_loader_if.sv
// Config stream bundle between the CPU-side source (CSR/DMA) and the loader.
interface rca_config_loader_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_abort;

  modport master (output cfg_data, output cfg_valid, output cfg_abort, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input cfg_abort, output cfg_ready);
endinterface

// File: rtl/rca_config_loader.sv
// Streaming loader: header + N entry words -> single-cycle config register writes.
// Optional macro RCA_CFG_LOADER_RANGE_CHECK_EN: out-of-range index/value/RCA id
// sets err and suppresses the strobe instead of truncating.
module rca_config_loader #(
  parameter int unsigned NUM_RCAS           = 4,
  parameter int unsigned NUM_READ_PORTS     = 2,
  parameter int unsigned NUM_WRITE_PORTS    = 2,
  parameter int unsigned GRID_NUM_ROWS      = 4,
  parameter int unsigned NUM_GRID_MUXES     = 32,
  parameter int unsigned GRID_MUX_INPUTS    = 8,
  parameter int unsigned IO_UNIT_MUX_INPUTS = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  rca_config_loader_if.slave                     cfg,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [$clog2(NUM_RCAS)-1:0]            rca_sel,
  output logic                                   cpu_fb_reg_addr_wr_en,
  output logic                                   cpu_nfb_reg_addr_wr_en,
  output logic                                   cpu_src_dest_port,
  output logic [$clog2(NUM_READ_PORTS)-1:0]      cpu_port_sel,
  output logic [4:0]                             cpu_reg_addr,
  output logic                                   grid_mux_wr_en,
  output logic [$clog2(NUM_GRID_MUXES)-1:0]      grid_mux_wr_addr,
  output logic [$clog2(GRID_MUX_INPUTS)-1:0]     new_grid_mux_sel,
  output logic                                   io_mux_wr_en,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]       io_mux_addr,
  output logic [$clog2(IO_UNIT_MUX_INPUTS)-1:0]  new_io_mux_sel,
  output logic                                   rca_result_mux_wr_en,
  output logic [$clog2(NUM_WRITE_PORTS)-1:0]     rca_result_mux_addr,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]       new_rca_result_mux_sel,
  output logic                                   rca_io_inp_map_wr_en,
  output logic [GRID_NUM_ROWS-1:0]               new_rca_io_inp_map
);

  localparam int unsigned RCA_W = $clog2(NUM_RCAS);
  localparam int unsigned RP_W  = $clog2(NUM_READ_PORTS);
  localparam int unsigned WP_W  = $clog2(NUM_WRITE_PORTS);
  localparam int unsigned GA_W  = $clog2(NUM_GRID_MUXES);
  localparam int unsigned GS_W  = $clog2(GRID_MUX_INPUTS);
  localparam int unsigned IA_W  = $clog2(GRID_NUM_ROWS);
  localparam int unsigned IS_W  = $clog2(IO_UNIT_MUX_INPUTS);
  localparam int unsigned RS_W  = $clog2(GRID_NUM_ROWS);
  localparam int unsigned REG_W = 5;
  localparam int unsigned MAP_W = GRID_NUM_ROWS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic [RCA_W-1:0] rca_sel_q, rca_sel_d;
  logic             fb_en_q, fb_en_d, nfb_en_q, nfb_en_d, sd_q, sd_d;
  logic [RP_W-1:0]  port_q, port_d;
  logic [REG_W-1:0] reg_q, reg_d;
  logic             grid_en_q, grid_en_d, io_en_q, io_en_d, res_en_q, res_en_d, map_en_q, map_en_d;
  logic [GA_W-1:0]  ga_q, ga_d;
  logic [GS_W-1:0]  gs_q, gs_d;
  logic [IA_W-1:0]  ia_q, ia_d;
  logic [IS_W-1:0]  is_q, is_d;
  logic [WP_W-1:0]  ra_q, ra_d;
  logic [RS_W-1:0]  rs_q, rs_d;
  logic [MAP_W-1:0] map_q, map_d;

  logic [2:0]  typ;
  logic [7:0]  idx;
  logic [15:0] val;
  logic        accept, in_range, hdr_rca_bad;
  logic        unused_data;

  assign typ         = cfg.cfg_data[31:29];
  assign idx         = cfg.cfg_data[23:16];
  assign val         = cfg.cfg_data[15:0];
  assign unused_data = ^cfg.cfg_data;

  // Ready depends only on state and abort; forced low while in reset.
  assign cfg.cfg_ready = rst_n & ~cfg.cfg_abort & (state_q != DONE);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

`ifdef RCA_CFG_LOADER_RANGE_CHECK_EN
  logic rca_bad_q, rca_bad_d;

  // Destination bounds for the current entry; a bad header RCA id poisons the whole load.
  always_comb begin
    hdr_rca_bad = (32'(cfg.cfg_data[15:8]) >= NUM_RCAS);
    case (typ)
      3'd0:         in_range = (32'(idx) < NUM_GRID_MUXES)  && (32'(val) < GRID_MUX_INPUTS);
      3'd1:         in_range = (32'(idx) < GRID_NUM_ROWS)   && (32'(val) < IO_UNIT_MUX_INPUTS);
      3'd2:         in_range = (32'(idx) < NUM_WRITE_PORTS) && (32'(val) < GRID_NUM_ROWS);
      3'd3:         in_range = (32'(idx) < NUM_READ_PORTS)  && (32'(val) < 32'd32);
      3'd4, 3'd5:   in_range = (32'(idx) < NUM_WRITE_PORTS) && (32'(val) < 32'd32);
      3'd6:         in_range = (32'(val) < (32'd1 << MAP_W));
      default:      in_range = 1'b1;
    endcase
    if (rca_bad_q) in_range = 1'b0;
  end

  // Latches whether the current load targets a nonexistent RCA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rca_bad_q <= 1'b0;
    else        rca_bad_q <= rca_bad_d;
  end

  assign rca_bad_d = (state_q == IDLE && accept) ? hdr_rca_bad : rca_bad_q;
`else
  assign hdr_rca_bad = 1'b0;
  assign in_range    = 1'b1;
`endif

  // Next-state, counter and write-strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rca_sel_d = rca_sel_q;
    fb_en_d   = 1'b0;
    nfb_en_d  = 1'b0;
    grid_en_d = 1'b0;
    io_en_d   = 1'b0;
    res_en_d  = 1'b0;
    map_en_d  = 1'b0;
    sd_d      = sd_q;
    port_d    = port_q;
    reg_d     = reg_q;
    ga_d      = ga_q;
    gs_d      = gs_q;
    ia_d      = ia_q;
    is_d      = is_q;
    ra_d      = ra_q;
    rs_d      = rs_q;
    map_d     = map_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rca_sel_d = RCA_W'(cfg.cfg_data[15:8]);
          cnt_d     = cfg.cfg_data[7:0];
          err_d     = hdr_rca_bad;
          state_d   = (cfg.cfg_data[7:0] == 8'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (cfg.cfg_abort) begin
          state_d = IDLE;
        end else if (accept) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = DONE;
          if (typ == 3'd7 || !in_range) begin
            err_d = 1'b1;
          end else begin
            case (typ)
              3'd0: begin grid_en_d = 1'b1; ga_d = GA_W'(idx); gs_d = GS_W'(val); end
              3'd1: begin io_en_d = 1'b1; ia_d = IA_W'(idx); is_d = IS_W'(val); end
              3'd2: begin res_en_d = 1'b1; ra_d = WP_W'(idx); rs_d = RS_W'(val); end
              3'd3: begin fb_en_d = 1'b1; sd_d = 1'b0; port_d = RP_W'(idx); reg_d = REG_W'(val); end
              3'd4: begin fb_en_d = 1'b1; sd_d = 1'b1; port_d = RP_W'(idx); reg_d = REG_W'(val); end
              3'd5: begin nfb_en_d = 1'b1; sd_d = 1'b1; port_d = RP_W'(idx); reg_d = REG_W'(val); end
              default: begin map_en_d = 1'b1; map_d = MAP_W'(val); end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD);
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  cnt_q <= '0;  err_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
      rca_sel_q <= '0;  fb_en_q <= 1'b0;  nfb_en_q <= 1'b0;  sd_q <= 1'b0;
      port_q <= '0;  reg_q <= '0;  grid_en_q <= 1'b0;  io_en_q <= 1'b0;
      res_en_q <= 1'b0;  map_en_q <= 1'b0;  ga_q <= '0;  gs_q <= '0;
      ia_q <= '0;  is_q <= '0;  ra_q <= '0;  rs_q <= '0;  map_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  err_q <= err_d;  busy_q <= busy_d;  done_q <= done_d;
      rca_sel_q <= rca_sel_d;  fb_en_q <= fb_en_d;  nfb_en_q <= nfb_en_d;  sd_q <= sd_d;
      port_q <= port_d;  reg_q <= reg_d;  grid_en_q <= grid_en_d;  io_en_q <= io_en_d;
      res_en_q <= res_en_d;  map_en_q <= map_en_d;  ga_q <= ga_d;  gs_q <= gs_d;
      ia_q <= ia_d;  is_q <= is_d;  ra_q <= ra_d;  rs_q <= rs_d;  map_q <= map_d;
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign err                    = err_q;
  assign rca_sel                = rca_sel_q;
  assign cpu_fb_reg_addr_wr_en  = fb_en_q;
  assign cpu_nfb_reg_addr_wr_en = nfb_en_q;
  assign cpu_src_dest_port      = sd_q;
  assign cpu_port_sel           = port_q;
  assign cpu_reg_addr           = reg_q;
  assign grid_mux_wr_en         = grid_en_q;
  assign grid_mux_wr_addr       = ga_q;
  assign new_grid_mux_sel       = gs_q;
  assign io_mux_wr_en           = io_en_q;
  assign io_mux_addr            = ia_q;
  assign new_io_mux_sel         = is_q;
  assign rca_result_mux_wr_en   = res_en_q;
  assign rca_result_mux_addr    = ra_q;
  assign new_rca_result_mux_sel = rs_q;
  assign rca_io_inp_map_wr_en   = map_en_q;
  assign new_rca_io_inp_map     = map_q;

endmodule

// File: tb/tb_rca_config_loader.sv
// Directed self-checking bench for rca_config_loader.
module tb_rca_config_loader;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rca_config_loader_if cfg_if ();

  logic       busy, done, err;
  logic [1:0] rca_sel;
  logic       fb_en, nfb_en, sd;
  logic [0:0] port_sel;
  logic [4:0] reg_addr;
  logic       grid_en;
  logic [4:0] grid_addr;
  logic [2:0] grid_sel;
  logic       io_en;
  logic [1:0] io_addr;
  logic [2:0] io_sel;
  logic       res_en;
  logic [0:0] res_addr;
  logic [1:0] res_sel;
  logic       map_en;
  logic [3:0] map_val;
  logic [5:0] en;

  rca_config_loader dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cfg                    (cfg_if),
    .busy                   (busy),
    .done                   (done),
    .err                    (err),
    .rca_sel                (rca_sel),
    .cpu_fb_reg_addr_wr_en  (fb_en),
    .cpu_nfb_reg_addr_wr_en (nfb_en),
    .cpu_src_dest_port      (sd),
    .cpu_port_sel           (port_sel),
    .cpu_reg_addr           (reg_addr),
    .grid_mux_wr_en         (grid_en),
    .grid_mux_wr_addr       (grid_addr),
    .new_grid_mux_sel       (grid_sel),
    .io_mux_wr_en           (io_en),
    .io_mux_addr            (io_addr),
    .new_io_mux_sel         (io_sel),
    .rca_result_mux_wr_en   (res_en),
    .rca_result_mux_addr    (res_addr),
    .new_rca_result_mux_sel (res_sel),
    .rca_io_inp_map_wr_en   (map_en),
    .new_rca_io_inp_map     (map_val)
  );

  // One-hot strobe view: grid, io, result, fb, nfb, map.
  assign en = {grid_en, io_en, res_en, fb_en, nfb_en, map_en};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] n, input logic [7:0] rca);
    return {16'h0000, rca, n};
  endfunction

  function automatic logic [31:0] ent(input logic [2:0] t, input logic [7:0] i, input logic [15:0] v);
    return {t, 5'b00000, i, v};
  endfunction

  initial begin
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    cfg_if.cfg_abort = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", 32'(cfg_if.cfg_ready), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rca", 32'(rca_sel), 0);
    #6 rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(cfg_if.cfg_ready), 1);

    // Three back-to-back entries to RCA 2
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = hdr(8'd3, 8'd2);
    tick();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_rca", 32'(rca_sel), 2);
    chk("t1_hdr_en", 32'(en), 0);
    cfg_if.cfg_data = ent(3'd0, 8'd5, 16'd3);
    tick();
    chk("t1_grid_en", 32'(en), 32'b100000);
    chk("t1_grid_addr", 32'(grid_addr), 5);
    chk("t1_grid_sel", 32'(grid_sel), 3);
    chk("t1_nodone", 32'(done), 0);
    cfg_if.cfg_data = ent(3'd1, 8'd1, 16'd7);
    tick();
    chk("t1_io_en", 32'(en), 32'b010000);
    chk("t1_io_addr", 32'(io_addr), 1);
    chk("t1_io_sel", 32'(io_sel), 7);
    cfg_if.cfg_data = ent(3'd2, 8'd1, 16'd2);
    tick();
    chk("t1_res_en", 32'(en), 32'b001000);
    chk("t1_res_addr", 32'(res_addr), 1);
    chk("t1_res_sel", 32'(res_sel), 2);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_ready_done", 32'(cfg_if.cfg_ready), 0);
    chk("t1_rca_hold", 32'(rca_sel), 2);
    cfg_if.cfg_valid = 1'b0;
    tick();
    chk("t1_done_clr", 32'(done), 0);
    chk("t1_en_clr", 32'(en), 0);

    // Empty load
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = hdr(8'd0, 8'd1);
    tick();
    chk("t2_done", 32'(done), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_en", 32'(en), 0);
    chk("t2_rca", 32'(rca_sel), 1);
    cfg_if.cfg_valid = 1'b0;
    tick();
    chk("t2_done_clr", 32'(done), 0);

    // CPU register types and invalid type
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = hdr(8'd4, 8'd0);
    tick();
    cfg_if.cfg_data = ent(3'd3, 8'd1, 16'd17);
    tick();
    chk("t3_src_en", 32'(en), 32'b000100);
    chk("t3_src_sd", 32'(sd), 0);
    chk("t3_src_port", 32'(port_sel), 1);
    chk("t3_src_reg", 32'(reg_addr), 17);
    cfg_if.cfg_data = ent(3'd4, 8'd1, 16'd17);
    tick();
    chk("t3_dfb_en", 32'(en), 32'b000100);
    chk("t3_dfb_sd", 32'(sd), 1);
    chk("t3_dfb_reg", 32'(reg_addr), 17);
    cfg_if.cfg_data = ent(3'd5, 8'd1, 16'd17);
    tick();
    chk("t3_dnfb_en", 32'(en), 32'b000010);
    chk("t3_dnfb_sd", 32'(sd), 1);
    chk("t3_dnfb_port", 32'(port_sel), 1);
    chk("t3_dnfb_reg", 32'(reg_addr), 17);
    cfg_if.cfg_data = ent(3'd7, 8'd0, 16'd0);
    tick();
    chk("t3_inv_en", 32'(en), 0);
    chk("t3_inv_err", 32'(err), 1);
    chk("t3_inv_done", 32'(done), 1);
    cfg_if.cfg_valid = 1'b0;
    tick();
    chk("t3_err_sticky", 32'(err), 1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = hdr(8'd1, 8'd3);
    tick();
    chk("t3_err_clr", 32'(err), 0);
    chk("t3_rca", 32'(rca_sel), 3);
    cfg_if.cfg_data = ent(3'd6, 8'd0, 16'd5);
    tick();
    chk("t3_map_en", 32'(en), 32'b000001);
    chk("t3_map_val", 32'(map_val), 5);
    chk("t3_map_done", 32'(done), 1);
    cfg_if.cfg_valid = 1'b0;
    tick();

    // Gappy valid, abort after 2 of 4 entries
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = hdr(8'd4, 8'd1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    tick();
    chk("t4_gap_en", 32'(en), 0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = ent(3'd0, 8'd2, 16'd1);
    tick();
    chk("t4_e1_en", 32'(en), 32'b100000);
    chk("t4_e1_addr", 32'(grid_addr), 2);
    cfg_if.cfg_valid = 1'b0;
    tick();
    chk("t4_gap2_en", 32'(en), 0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = ent(3'd1, 8'd3, 16'd4);
    tick();
    chk("t4_e2_en", 32'(en), 32'b010000);
    chk("t4_e2_addr", 32'(io_addr), 3);
    chk("t4_e2_sel", 32'(io_sel), 4);
    cfg_if.cfg_abort = 1'b1;
    cfg_if.cfg_data  = ent(3'd0, 8'd7, 16'd7);
    #1;
    chk("t4_abort_ready", 32'(cfg_if.cfg_ready), 0);
    tick();
    chk("t4_abort_en", 32'(en), 0);
    chk("t4_abort_busy", 32'(busy), 0);
    chk("t4_abort_done", 32'(done), 0);
    cfg_if.cfg_abort = 1'b0;
    cfg_if.cfg_data  = hdr(8'd0, 8'd2);
    #1;
    chk("t4_idle_ready", 32'(cfg_if.cfg_ready), 1);
    tick();
    chk("t4_hdr_done", 32'(done), 1);
    chk("t4_hdr_rca", 32'(rca_sel), 2);
    cfg_if.cfg_valid = 1'b0;
    tick();

    // Grid index beyond the mux count
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = hdr(8'd1, 8'd0);
    tick();
    cfg_if.cfg_data = ent(3'd0, 8'd40, 16'd2);
    tick();
`ifdef RCA_CFG_LOADER_RANGE_CHECK_EN
    chk("t5_rc_en", 32'(en), 0);
    chk("t5_rc_err", 32'(err), 1);
`else
    chk("t5_trunc_en", 32'(en), 32'b100000);
    chk("t5_trunc_addr", 32'(grid_addr), 8);
    chk("t5_trunc_err", 32'(err), 0);
`endif
    chk("t5_done", 32'(done), 1);
    cfg_if.cfg_valid = 1'b0;
    tick();

    // Reset while a strobe is pending
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = hdr(8'd2, 8'd1);
    tick();
    cfg_if.cfg_data = ent(3'd0, 8'd3, 16'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(cfg_if.cfg_ready), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_rca", 32'(rca_sel), 0);
    cfg_if.cfg_valid = 1'b0;
    tick();
    chk("t6_rst_en", 32'(en), 0);
    chk("t6_rst_addr", 32'(grid_addr), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_ready2", 32'(cfg_if.cfg_ready), 0);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_rel_ready", 32'(cfg_if.cfg_ready), 1);
    chk("t6_rel_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
